dpram_arbiter: RTL
==================

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive grants to a locked requester while the other requester is pending.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have ports m0_req_i/m0_we_i/m0_lock_i, input, 1 each: CPU mem-stage request, write enable and burst lock.
REQ-005 SHALL have ports m0_addr_i/m0_wdata_i, input, `XLEN each: CPU byte address and write data.
REQ-006 SHALL have ports m0_gnt_o/m0_rvalid_o, output, 1 each, and m0_rdata_o, output, `XLEN: CPU grant, read-data valid and read data.
REQ-007 SHALL have an identical m1_* port set (req, we, lock, addr, wdata, gnt, rvalid, rdata) for the heap engine.
REQ-008 SHALL have ports ram_req_o/ram_we_o, output, 1 each: the dpram data-port request and write strobe.
REQ-009 SHALL have ports ram_addr_o/ram_data_o, output, `XLEN each, and ram_data_i, input, `XLEN: dpram data-port address, write data and combinational read data.

Function
REQ-010 SHALL grant at most one requester per cycle; gnt is combinational from the req inputs and internal state, asserted in the same cycle as req.
REQ-011 SHALL drive ram_req_o=1, and ram_we_o/ram_data_o from the granted master, only in a grant cycle; otherwise all ram_* outputs SHALL be 0.
REQ-012 SHALL drive ram_addr_o as the granted address with bits [1:0] forced to 0 (word-aligned); an unaligned request SHALL be served at the aligned word.
REQ-013 SHALL register ram_data_i at the grant edge for a read; the matching rvalid is 1 for exactly one cycle, the cycle after the grant, with rdata holding that word.
REQ-014 SHALL give write grants no rvalid pulse; rdata SHALL hold its last value when rvalid is 0.
REQ-015 SHALL keep a last-grant pointer (reset value: m1), so that m0 wins the first contention after reset.
REQ-016 SHALL arbitrate round-robin when both requesters are pending and no lock applies: the master not pointed to wins.
REQ-017 SHALL give a master that was granted last cycle, is requesting again and holds lock_i priority while burst count < MAX_BURST.
REQ-018 SHALL run a burst counter: count=1 on the first grant to a master, incremented on each further consecutive grant to the same master while the other is pending, reset to 0 on a grant switch or an idle cycle.
REQ-019 SHALL grant the other pending master when the burst count reaches MAX_BURST, regardless of lock.
REQ-020 SHALL give a master requesting alone the grant every cycle, with no MAX_BURST limit; the counter is held at 0.
REQ-021 SHALL leave pointer and counter unchanged in a cycle with no requests; the m0 and m1 rvalid signals are never 1 together.

Reset
REQ-022 SHALL, while rst_ni=0: all gnt, rvalid and ram_* outputs at 0, both rdata at 0, counter at 0, pointer at m1.
REQ-023 SHALL, on reset asserted mid-burst or on a read issued in the cycle before reset, drop all pending rvalid pulses without generating them after release.
REQ-024 SHALL make its first grant possible in the first cycle after rst_ni rises.

Structure
REQ-025 SHALL take `XLEN from defines.v; a shared package SHALL hold the master-index enum (MST_CPU=0, MST_HEAP=1) and the default MAX_BURST constant.
REQ-026 SHALL place the pointer/counter/lock decision in one sub-module, rr_lock_arb, returning a one-hot grant; the top handles datapath muxing and response registers.

Verification
REQ-027 SHALL cover: both idle, then m0 read of 0x10 with the dpram holding 0xDEADBEEF -> m0_gnt_o=1 same cycle, m0_rvalid_o=1 and m0_rdata_o=0xDEADBEEF next cycle.
REQ-028 SHALL cover: m0 and m1 requesting continuously without lock -> grants alternate m0, m1, m0, m1, starting with m0 after reset.
REQ-029 SHALL cover: m1 lock=1 with m0 pending, MAX_BURST=4 -> four consecutive m1 grants, then one m0 grant.
REQ-030 SHALL cover: m1 write 0x12345678 to address 0x23 -> ram_addr_o=0x20, ram_we_o=1, no m1_rvalid_o; a later read of 0x20 returns 0x12345678.
REQ-031 SHALL cover: rst_ni pulsed low in the cycle after an m0 read grant -> m0_rvalid_o stays 0 and m0_rdata_o=0.
REQ-032 SHALL cover: m0 requesting alone with lock for 10 cycles -> 10 consecutive grants, burst counter stays 0.

Source files
------------

// File: rtl/dpram_arbiter_pkg.sv
// Shared types and constants for the two-master dpram data-port arbiter.
`include "defines.v"

package dpram_arbiter_pkg;

    localparam int XLEN              = `XLEN;
    localparam int NUM_MST           = 2;
    localparam int DEFAULT_MAX_BURST = 4;

    typedef enum logic {
        MST_CPU  = 1'b0,
        MST_HEAP = 1'b1
    } mst_e;

    typedef struct packed {
        logic            req;
        logic            we;
        logic            lock;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mst_req_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic mst_e other_mst(input mst_e m);
        return (m == MST_CPU) ? MST_HEAP : MST_CPU;
    endfunction

endpackage

// File: rtl/defines.v
// Global core-wide defines shared by the memory subsystem.
`ifndef DEFINES_V
`define DEFINES_V
`define XLEN 32
`endif

// File: rtl/dpram_arbiter_rr_lock_arb.sv
// Round-robin arbiter with burst lock: last-grant pointer plus a burst counter
// that caps how long a locked master may starve a pending competitor.
module rr_lock_arb
    import dpram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_MST-1:0] req,
    input  logic [NUM_MST-1:0] lock,
    output logic [NUM_MST-1:0] gnt
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    mst_e               ptr_reg, ptr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               prev_gnt_reg, prev_gnt_next;
    logic [NUM_MST-1:0] gnt_raw;
    mst_e               winner;
    logic               lock_hold;

    // The pointed master keeps the port only if it was granted in the very
    // previous cycle, still locks, and has not used up its burst allowance.
    assign lock_hold = prev_gnt_reg && req[ptr_reg] && lock[ptr_reg]
                       && (cnt_reg < CNT_W'(MAX_BURST));

    always_comb begin
        gnt_raw       = '0;
        winner        = ptr_reg;
        ptr_next      = ptr_reg;
        cnt_next      = cnt_reg;
        prev_gnt_next = 1'b0;
        case (req)
            2'b01: begin
                winner   = MST_CPU;
                cnt_next = '0;
            end
            2'b10: begin
                winner   = MST_HEAP;
                cnt_next = '0;
            end
            2'b11: begin
                winner = lock_hold ? ptr_reg : other_mst(ptr_reg);
                if (prev_gnt_reg && (winner == ptr_reg))
                    cnt_next = cnt_reg + CNT_W'(1);
                else
                    cnt_next = CNT_W'(1);
            end
            default: ;
        endcase
        if (|req) begin
            gnt_raw[winner] = 1'b1;
            ptr_next        = winner;
            prev_gnt_next   = 1'b1;
        end
    end

    assign gnt = gnt_raw & {NUM_MST{rst_ni}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_reg      <= MST_HEAP;
            cnt_reg      <= '0;
            prev_gnt_reg <= 1'b0;
        end else begin
            ptr_reg      <= ptr_next;
            cnt_reg      <= cnt_next;
            prev_gnt_reg <= prev_gnt_next;
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares the dpram data port between the CPU mem stage (m0) and the heap
// engine (m1); muxes the granted request onto the port and returns read data.
`include "defines.v"

module dpram_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             m0_req_i,
    input  logic             m0_we_i,
    input  logic             m0_lock_i,
    input  logic [`XLEN-1:0] m0_addr_i,
    input  logic [`XLEN-1:0] m0_wdata_i,
    output logic             m0_gnt_o,
    output logic             m0_rvalid_o,
    output logic [`XLEN-1:0] m0_rdata_o,
    input  logic             m1_req_i,
    input  logic             m1_we_i,
    input  logic             m1_lock_i,
    input  logic [`XLEN-1:0] m1_addr_i,
    input  logic [`XLEN-1:0] m1_wdata_i,
    output logic             m1_gnt_o,
    output logic             m1_rvalid_o,
    output logic [`XLEN-1:0] m1_rdata_o,
    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [`XLEN-1:0] ram_addr_o,
    output logic [`XLEN-1:0] ram_data_o,
    input  logic [`XLEN-1:0] ram_data_i
);

    mst_req_t           mreq [NUM_MST];
    logic [NUM_MST-1:0] req_vec;
    logic [NUM_MST-1:0] lock_vec;
    logic [NUM_MST-1:0] gnt;
    logic [NUM_MST-1:0] rvalid_vec;
    logic [XLEN-1:0]    rdata_vec [NUM_MST];

    assign mreq[0] = '{req: m0_req_i, we: m0_we_i, lock: m0_lock_i,
                       addr: m0_addr_i, wdata: m0_wdata_i};
    assign mreq[1] = '{req: m1_req_i, we: m1_we_i, lock: m1_lock_i,
                       addr: m1_addr_i, wdata: m1_wdata_i};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MST; gi++) begin : g_pack
            assign req_vec[gi]  = mreq[gi].req;
            assign lock_vec[gi] = mreq[gi].lock;
        end
    endgenerate

    rr_lock_arb #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (req_vec),
        .lock   (lock_vec),
        .gnt    (gnt)
    );

    // The port is fully quiet outside grant cycles so the dpram never sees a
    // stale address or write data from an unserved master.
    always_comb begin
        ram_req_o  = |gnt;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (gnt[i]) begin
                ram_we_o   = mreq[i].we;
                ram_addr_o = word_align(mreq[i].addr);
                ram_data_o = mreq[i].wdata;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_MST; gi++) begin : g_resp
            logic            rvalid_reg;
            logic [XLEN-1:0] rdata_reg;
            logic            rd_gnt;

            assign rd_gnt = gnt[gi] & ~mreq[gi].we;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= rd_gnt;
                    if (rd_gnt)
                        rdata_reg <= ram_data_i;
                end
            end

            assign rvalid_vec[gi] = rvalid_reg;
            assign rdata_vec[gi]  = rdata_reg;
        end
    endgenerate

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_rvalid_o = rvalid_vec[0];
    assign m1_rvalid_o = rvalid_vec[1];
    assign m0_rdata_o  = rdata_vec[0];
    assign m1_rdata_o  = rdata_vec[1];

endmodule
